// File: rtl/tehb_dataless_fifo_if.sv
// Handshake bundle for the dataless ready-cutting buffer.
// Valid/ready contract: a token moves on a cycle where valid and ready are both high.
// A producer may drop valid at any time. The buffer keeps outs_valid asserted until the token is taken.
interface tehb_dataless_fifo_if;
  logic ins_valid;
  logic ins_ready;
  logic outs_valid;
  logic outs_ready;

  modport master (
    output ins_valid,
    output outs_ready,
    input  ins_ready,
    input  outs_valid
  );

  modport slave (
    input  ins_valid,
    input  outs_ready,
    output ins_ready,
    output outs_valid
  );
endinterface

// File: rtl/tehb_dataless_fifo.sv
// Dataless elastic buffer that registers the ready path. It tracks up to NUM_SLOTS tokens
// as an occupancy count and passes tokens straight through with no latency while empty.
module tehb_dataless_fifo #(
  parameter int NUM_SLOTS = 4,
  localparam int CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  tehb_dataless_fifo_if.slave hs,
  output logic [CNT_W-1:0] occupancy
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ready_q;
  logic             ready_next;
  logic             enq;
  logic             deq;
  logic             valid;

  // ins_ready comes only from ready_q, so outs_ready never reaches it combinationally.
  assign enq          = hs.ins_valid & ready_q;
  assign valid        = (count != '0) | enq;
  assign deq          = valid & hs.outs_ready;
  assign hs.ins_ready = ready_q;
  assign hs.outs_valid = valid;
  assign occupancy    = count;

  always_comb begin
    count_next = count;
    if (enq && !deq) begin
      count_next = count + 1'b1;
    end else if (!enq && deq) begin
      count_next = count - 1'b1;
    end
    ready_next = (count_next < CNT_W'(NUM_SLOTS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      ready_q <= ready_next;
    end
  end

endmodule
